// File: rtl/match_rdo_sched.sv
// match_rdo_sched: queues L1A-tagged readout requests and issues them in order over REQ/ACK/DONE.
// Optional feature macro NOMATCH_RDO_EN: NO_MATCH pulses also queue header-only readouts.
module match_rdo_sched #(
   parameter int DEPTH   = 8,
   parameter int TAGW    = 12,
   parameter int GAP_CYC = 2,
   parameter int TMO_CYC = 255
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     L1A,
   input  logic                     MATCH,
   input  logic                     NO_MATCH,
   input  logic                     RDO_ACK,
   input  logic                     RDO_DONE,
   output logic                     RDO_REQ,
   output logic [TAGW-1:0]          RDO_TAG,
   output logic                     RDO_NOMTCH,
   output logic [$clog2(DEPTH):0]   PENDING,
   output logic                     FULL,
   output logic                     BUSY,
   output logic [7:0]               OVFL_CNT,
   output logic [7:0]               TMO_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef NOMATCH_RDO_EN
   localparam int EW = TAGW + 1;
`else
   localparam int EW = TAGW;
`endif
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [9:0]    TMO_LAST = 10'(TMO_CYC - 1);
   localparam logic [3:0]    GAP_LAST = 4'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t          state_r, next_s, exit_state_s;
   logic [TAGW-1:0] tag_cnt_r;
   logic [EW-1:0]   mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic            full_r, req_r, busy_r;
   logic [TAGW-1:0] rdo_tag_r;
   logic [7:0]      ovfl_r, tmo_cnt_r;
   logic [9:0]      tmo_tmr_r;
   logic [3:0]      gap_tmr_r;
   logic            push_s, pop_s, wr_en_s, drop_s, tmo_hit_s;
   logic [EW-1:0]   wr_data_s, head_s;
`ifdef NOMATCH_RDO_EN
   logic            nomtch_r;
`else
   logic            unused_nomatch_s;
`endif

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign head_s = mem_r[rd_ptr_r];

   // FIFO push/pop qualification and next occupancy
   always_comb begin
      pop_s = (state_r == S_REQ) && RDO_ACK;
`ifdef NOMATCH_RDO_EN
      push_s    = MATCH || NO_MATCH;
      wr_data_s = {~MATCH, tag_cnt_r};
`else
      push_s    = MATCH;
      wr_data_s = tag_cnt_r;
`endif
      wr_en_s = push_s && (!full_r || pop_s);
      drop_s  = push_s && full_r && !pop_s;
      case ({wr_en_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CW'(1);
         2'b01:   cnt_nxt_s = cnt_r - CW'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Scheduler next state; leaving a readout goes straight to REQ when work is queued
   always_comb begin
      next_s       = state_r;
      tmo_hit_s    = 1'b0;
      exit_state_s = (cnt_r != {CW{1'b0}}) ? S_REQ : S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (cnt_r != {CW{1'b0}}) next_s = S_REQ;
            else                     next_s = S_IDLE;
         end
         S_REQ: begin
            if (RDO_ACK) next_s = S_WAIT;
            else         next_s = S_REQ;
         end
         S_WAIT: begin
            if (RDO_DONE || (tmo_tmr_r == TMO_LAST)) begin
               tmo_hit_s = ~RDO_DONE;
               next_s    = (GAP_CYC == 0) ? exit_state_s : S_GAP;
            end else begin
               next_s = S_WAIT;
            end
         end
         S_GAP: begin
            if (gap_tmr_r == GAP_LAST) next_s = exit_state_s;
            else                       next_s = S_GAP;
         end
         default: next_s = S_IDLE;
      endcase
   end

   // Scheduler state, timers and handshake outputs
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r   <= S_IDLE;
         req_r     <= 1'b0;
         busy_r    <= 1'b0;
         rdo_tag_r <= {TAGW{1'b0}};
         tmo_tmr_r <= 10'd0;
         gap_tmr_r <= 4'd0;
         tmo_cnt_r <= 8'd0;
`ifdef NOMATCH_RDO_EN
         nomtch_r  <= 1'b0;
`endif
      end else begin
         state_r <= next_s;
         req_r   <= (next_s == S_REQ);
         busy_r  <= (next_s != S_IDLE);
         if ((next_s == S_REQ) && (state_r != S_REQ)) begin
            rdo_tag_r <= head_s[TAGW-1:0];
`ifdef NOMATCH_RDO_EN
            nomtch_r  <= head_s[TAGW];
`endif
         end
         tmo_tmr_r <= (state_r == S_WAIT) ? tmo_tmr_r + 10'd1 : 10'd0;
         gap_tmr_r <= (state_r == S_GAP)  ? gap_tmr_r + 4'd1  : 4'd0;
         if (tmo_hit_s) tmo_cnt_r <= sat_inc(tmo_cnt_r);
      end
   end

   // FIFO pointers, occupancy, tag counter and overflow counter
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         cnt_r     <= {CW{1'b0}};
         full_r    <= 1'b0;
         tag_cnt_r <= {TAGW{1'b0}};
         ovfl_r    <= 8'd0;
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
         cnt_r  <= cnt_nxt_s;
         full_r <= (cnt_nxt_s == DEPTH_C);
         if (L1A)    tag_cnt_r <= tag_cnt_r + TAGW'(1);
         if (drop_s) ovfl_r    <= sat_inc(ovfl_r);
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge CLK) begin
      if (RST_N && wr_en_s) mem_r[wr_ptr_r] <= wr_data_s;
   end

`ifdef NOMATCH_RDO_EN
   assign RDO_NOMTCH = nomtch_r;
`else
   assign RDO_NOMTCH       = 1'b0;
   assign unused_nomatch_s = NO_MATCH;
`endif
   assign RDO_REQ  = req_r;
   assign RDO_TAG  = rdo_tag_r;
   assign PENDING  = cnt_r;
   assign FULL     = full_r;
   assign BUSY     = busy_r;
   assign OVFL_CNT = ovfl_r;
   assign TMO_CNT  = tmo_cnt_r;

endmodule

// File: tb/tb_match_rdo_sched.sv
// Directed bench for match_rdo_sched (default build, DEPTH=8 TAGW=12 GAP_CYC=2 TMO_CYC=255).
module tb_match_rdo_sched;
   localparam int GAP = 2;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        L1A = 1'b0, MATCH = 1'b0, NO_MATCH = 1'b0, RDO_ACK = 1'b0, RDO_DONE = 1'b0;
   logic        RDO_REQ, RDO_NOMTCH, FULL, BUSY;
   logic [11:0] RDO_TAG;
   logic [3:0]  PENDING;
   logic [7:0]  OVFL_CNT, TMO_CNT;

   int n_cmp = 0;
   int n_bad = 0;
   logic [11:0] exp_q [$];

   typedef struct {
      logic        l1a;
      logic        match;
      logic        nomatch;
      logic        ack;
      logic        done;
      logic        exp_req;
      logic [11:0] exp_tag;
      logic        chk_tag;
      logic [3:0]  exp_pend;
      logic        exp_busy;
   } vec_t;
   vec_t tbl [12];

   match_rdo_sched #(.DEPTH(8), .TAGW(12), .GAP_CYC(2), .TMO_CYC(255)) dut (
      .CLK(CLK), .RST_N(RST_N), .L1A(L1A), .MATCH(MATCH), .NO_MATCH(NO_MATCH),
      .RDO_ACK(RDO_ACK), .RDO_DONE(RDO_DONE), .RDO_REQ(RDO_REQ), .RDO_TAG(RDO_TAG),
      .RDO_NOMTCH(RDO_NOMTCH), .PENDING(PENDING), .FULL(FULL), .BUSY(BUSY),
      .OVFL_CNT(OVFL_CNT), .TMO_CNT(TMO_CNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic l1a, input logic m, input logic nm, input logic ack, input logic done);
      L1A = l1a; MATCH = m; NO_MATCH = nm; RDO_ACK = ack; RDO_DONE = done;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   // Serve every queued request: ACK on sight, DONE the next cycle, check order and spacing.
   task automatic drain(input int n, input int w_init, input bit chk_first);
      int w;
      w = w_init;
      for (int k = 0; k < n; k++) begin
         while (RDO_REQ !== 1'b1 && w < 600) begin
            tick();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            w++;
         end
         chk($sformatf("drain_req_seen[%0d]", k), RDO_REQ, 1'b1);
         if (k > 0 || chk_first) chk($sformatf("gap_latency[%0d]", k), w, GAP + 1);
         chk($sformatf("drain_tag[%0d]", k), RDO_TAG, exp_q[k]);
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         chk($sformatf("req_drop_after_ack[%0d]", k), RDO_REQ, 1'b0);
         tick();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         w = 1;
      end
   endtask

   initial begin
      // l1a match nomatch ack done | req tag chk_tag pend busy
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 4'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 4'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 4'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 4'd1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd1, 1'b1, 4'd1, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd1, 1'b1, 4'd1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1, 1'b1, 4'd1, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 4'd0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 4'd0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 4'd0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 4'd0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 4'd0, 1'b0};

      // Single readout, latency, spurious ACK/DONE, ignored NO_MATCH
      do_reset();
      chk("rst_full", FULL, 1'b0);
      chk("rst_nomtch", RDO_NOMTCH, 1'b0);
      chk("rst_ovfl", OVFL_CNT, 8'd0);
      chk("rst_tmo", TMO_CNT, 8'd0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         chk($sformatf("t1_req[%0d]", k), RDO_REQ, tbl[k].exp_req);
         if (tbl[k].chk_tag) chk($sformatf("t1_tag[%0d]", k), RDO_TAG, tbl[k].exp_tag);
         chk($sformatf("t1_pend[%0d]", k), PENDING, tbl[k].exp_pend);
         chk($sformatf("t1_busy[%0d]", k), BUSY, tbl[k].exp_busy);
         drive(tbl[k].l1a, tbl[k].match, tbl[k].nomatch, tbl[k].ack, tbl[k].done);
      end

      // Overfill with 10 pushes (tags 0..9), then push+pop while full
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 2) chk("t2_req_latency", RDO_REQ, 1'b1);
         if (c == 7) begin
            chk("t2_pend7", PENDING, 4'd7);
            chk("t2_notfull7", FULL, 1'b0);
         end
         if (c == 8) begin
            chk("t2_pend8", PENDING, 4'd8);
            chk("t2_full8", FULL, 1'b1);
            chk("t2_ovfl8", OVFL_CNT, 8'd0);
         end
         if (c == 9) chk("t2_ovfl9", OVFL_CNT, 8'd1);
      end
      tick();
      chk("t2_pend", PENDING, 4'd8);
      chk("t2_full", FULL, 1'b1);
      chk("t2_ovfl", OVFL_CNT, 8'd2);
      chk("t2_req", RDO_REQ, 1'b1);
      chk("t2_head_tag", RDO_TAG, 12'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk("t3_pend", PENDING, 4'd8);
      chk("t3_full", FULL, 1'b1);
      chk("t3_ovfl", OVFL_CNT, 8'd2);
      chk("t3_req", RDO_REQ, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd10};
      drain(8, 1, 1'b1);
      repeat (4) tick();
      chk("t3_pend_empty", PENDING, 4'd0);
      chk("t3_idle", BUSY, 1'b0);

      // Tag counter wrap, and same-cycle L1A not seen by the push
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4095) tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q = '{12'd4095, 12'd0};
      drain(2, 0, 1'b0);

      // Timeout after 255 WAIT cycles; DONE on the expiry cycle is not a timeout
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_req", RDO_REQ, 1'b1);
      chk("t4_tag0", RDO_TAG, 12'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (254) begin
         tick();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick();
      chk("t4_tmo_before", TMO_CNT, 8'd0);
      chk("t4_busy_wait", BUSY, 1'b1);
      tick();
      chk("t4_tmo_after", TMO_CNT, 8'd1);
      chk("t4_req_gap1", RDO_REQ, 1'b0);
      tick();
      chk("t4_req_gap2", RDO_REQ, 1'b0);
      tick();
      chk("t4_req_next", RDO_REQ, 1'b1);
      chk("t4_tag1", RDO_TAG, 12'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (254) begin
         tick();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_done_at_expiry", TMO_CNT, 8'd1);

      // Reset pulse while REQ is up: everything clears, queue lost
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 20 && RDO_REQ !== 1'b1; w++) tick();
      chk("t6_req_before", RDO_REQ, 1'b1);
      RST_N = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      RST_N = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_req", RDO_REQ, 1'b0);
      chk("t6_tag", RDO_TAG, 12'd0);
      chk("t6_pend", PENDING, 4'd0);
      chk("t6_full", FULL, 1'b0);
      chk("t6_busy", BUSY, 1'b0);
      chk("t6_ovfl", OVFL_CNT, 8'd0);
      chk("t6_tmo", TMO_CNT, 8'd0);
      repeat (5) tick();
      chk("t6_req_later", RDO_REQ, 1'b0);
      chk("t6_pend_later", PENDING, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
